// File: rtl/axil_regbank.sv
// rtl/axil_regbank.sv - AXI4-Lite slave register bank with byte strobes, RO status mapping and access pulses
module axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_REGS = 16,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK = '0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_status,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]                    wr_pulse,
  output logic [C_NUM_REGS-1:0]                    rd_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int NB   = DW / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic [DW-1:0]   regs [C_NUM_REGS];
  logic            rdy_en;
  logic            aw_have, w_have;
  logic [AW-1:0]   awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   wstrb_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q;
  logic [C_NUM_REGS-1:0] wr_pulse_q, rd_pulse_q;

  logic            bvalid, rvalid, awready, wready, arready;
  logic            aw_hs, w_hs, ar_hs, commit;
  logic [AW-1:0]   wa, wa_word, ra_word;
  logic [DW-1:0]   wd;
  logic [NB-1:0]   ws;
  logic [IDXW-1:0] w_idx, r_idx;
  logic            w_ok, r_valid;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // Write channel: AW and W may arrive in any order; commit on the edge completing the pair
  assign aw_hs   = S_AXI_AWVALID & awready;
  assign w_hs    = S_AXI_WVALID & wready;
  assign wa      = aw_have ? awaddr_q : S_AXI_AWADDR;
  assign wd      = w_have ? wdata_q : S_AXI_WDATA;
  assign ws      = w_have ? wstrb_q : S_AXI_WSTRB;
  assign wa_word = wa >> LSB;
  assign w_idx   = wa[LSB +: IDXW];
  assign w_ok    = (wa_word < AW'(C_NUM_REGS)) & ~C_RO_MASK[w_idx];
  assign commit  = (wstate == W_IDLE) & (aw_have | aw_hs) & (w_have | w_hs);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wstate <= W_IDLE;
    else          wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE: if (commit) wstate_nxt = W_RESP;
      W_RESP: if (S_AXI_BREADY) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    bvalid  = (wstate == W_RESP);
    awready = rdy_en & ~aw_have & ~bvalid;
    wready  = rdy_en & ~w_have & ~bvalid;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en     <= 1'b0;
      aw_have    <= 1'b0;
      w_have     <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      rdy_en     <= 1'b1;
      wr_pulse_q <= '0;
      if (aw_hs) awaddr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_have <= 1'b0;
        w_have  <= 1'b0;
        bresp_q <= w_ok ? RESP_OKAY : RESP_SLVERR;
        if (w_ok) wr_pulse_q[w_idx] <= 1'b1;
      end else begin
        if (aw_hs) aw_have <= 1'b1;
        if (w_hs)  w_have  <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < C_NUM_REGS; k++) regs[k] <= '0;
    end else if (commit && w_ok) begin
      for (int b = 0; b < NB; b++)
        if (ws[b]) regs[w_idx][b*8 +: 8] <= wd[b*8 +: 8];
    end
  end

  // Read channel: response registered at the AR edge, so a same-edge write is not yet visible
  assign ar_hs   = S_AXI_ARVALID & arready;
  assign ra_word = S_AXI_ARADDR >> LSB;
  assign r_idx   = S_AXI_ARADDR[LSB +: IDXW];
  assign r_valid = (ra_word < AW'(C_NUM_REGS));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rstate <= R_IDLE;
    else          rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE: if (ar_hs) rstate_nxt = R_DATA;
      R_DATA: if (S_AXI_RREADY) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rvalid  = (rstate == R_DATA);
    arready = rdy_en & (rstate == R_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      rd_pulse_q <= '0;
      if (ar_hs) begin
        if (!r_valid) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end else begin
          rdata_q <= C_RO_MASK[r_idx] ? hw_status[r_idx*DW +: DW] : regs[r_idx];
          rresp_q <= RESP_OKAY;
          rd_pulse_q[r_idx] <= 1'b1;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < C_NUM_REGS; g++) begin : g_reg_out
      assign reg_out[g*DW +: DW] = C_RO_MASK[g] ? '0 : regs[g];
    end
  endgenerate

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign rd_pulse      = rd_pulse_q;

endmodule

// File: tb/tb_axil_regbank.sv
// tb/tb_axil_regbank.sv - scoreboard bench for axil_regbank (16 x 32-bit, register 5 read-only)
module tb_axil_regbank;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr = '0, araddr = '0;
  logic [2:0]       awprot = '0, arprot = '0;
  logic             awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [DW-1:0]    wdata = '0;
  logic [DW/8-1:0]  wstrb = '0;
  logic             awready, wready, bvalid, arready, rvalid;
  logic [1:0]       bresp, rresp;
  logic [DW-1:0]    rdata;
  logic [NR*DW-1:0] hw_status, reg_out;
  logic [NR-1:0]    wr_pulse, rd_pulse;

  axil_regbank #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .C_NUM_REGS(NR), .C_RO_MASK(16'h0020)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .hw_status(hw_status), .reg_out(reg_out), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  int checks = 0;
  int passes = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] model [NR];
  int wr_cnt [NR];
  int rd_cnt [NR];

  // Scoreboard: responses are popped and compared when the DUT hands them over
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NR; k++) begin
        if (wr_pulse[k]) wr_cnt[k]++;
        if (rd_pulse[k]) rd_cnt[k]++;
      end
      if (bvalid && bready) begin
        logic [1:0] eb;
        checks++;
        if (exp_b.size() == 0) $display("FAIL b_unexpected: got bresp=%b, required no response", bresp);
        else begin
          eb = exp_b.pop_front();
          if (bresp !== eb) $display("FAIL b_resp: got %b, required %b", bresp, eb);
          else passes++;
        end
      end
      if (rvalid && rready) begin
        logic [33:0] er;
        checks++;
        if (exp_r.size() == 0) $display("FAIL r_unexpected: got rdata=%h, required no response", rdata);
        else begin
          er = exp_r.pop_front();
          if ({rresp, rdata} !== er) $display("FAIL r_data: got resp=%b data=%h, required resp=%b data=%h", rresp, rdata, er[33:32], er[31:0]);
          else passes++;
        end
      end
    end
  end

  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[7:6] != 2'b00 || a[5:2] == 4'd5) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) model[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [7:0] a);
    if (a[7:6] != 2'b00) return {2'b10, 32'h0};
    if (a[5:2] == 4'd5) return {2'b00, 32'hDEADBEEF};
    return {2'b00, model[a[5:2]]};
  endfunction

  task automatic clear_counts();
    for (int k = 0; k < NR; k++) begin wr_cnt[k] = 0; rd_cnt[k] = 0; end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_hs, w_hs;
    @(posedge clk); #1;
    exp_b.push_back(model_write(a, d, s));
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      @(negedge clk); aw_hs = awvalid && awready; w_hs = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
    end
    checks++;
    if (awvalid || wvalid) $display("FAIL write_handshake: timeout at addr %h, required accept", a);
    else passes++;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic do_read(input logic [7:0] a);
    logic hs;
    @(posedge clk); #1;
    exp_r.push_back(model_read(a));
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20 && arvalid; i++) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
      if (hs) arvalid = 0;
    end
    checks++;
    if (arvalid) $display("FAIL read_handshake: timeout at addr %h, required accept", a);
    else passes++;
    arvalid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_b.size() != 0 || exp_r.size() != 0)
      $display("FAIL drain: %0d b and %0d r responses outstanding, required 0", exp_b.size(), exp_r.size());
    else passes++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wr_pulse, rd_pulse} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs, required 0");
    else passes++;
    checks++;
    if (reg_out !== '0) $display("FAIL reset_reg_out: got %h, required 0", reg_out);
    else passes++;
    rst_n = 1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) $display("FAIL ready_before_edge: got %b, required 000", {awready, wready, arready});
    else passes++;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) $display("FAIL ready_after_edge: got %b, required 111", {awready, wready, arready});
    else passes++;
  endtask

  task automatic test_basic();
    clear_counts();
    for (int i = 0; i < 4; i++) do_write(8'(i * 4), 32'(i + 1), 4'hF);
    drain();
    for (int i = 0; i < 4; i++) do_read(8'(i * 4));
    drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_cnt[i] !== 1 || rd_cnt[i] !== 1)
        $display("FAIL basic_pulses reg %0d: got wr=%0d rd=%0d, required 1/1", i, wr_cnt[i], rd_cnt[i]);
      else passes++;
    end
  endtask

  task automatic test_strobe();
    do_write(8'h08, 32'hAABBCCDD, 4'hF);
    do_write(8'h08, 32'h11223344, 4'b0101);
    drain();
    checks++;
    if (reg_out[2*DW +: DW] !== 32'hAA22CC44) $display("FAIL strobe_reg_out: got %h, required aa22cc44", reg_out[2*DW +: DW]);
    else passes++;
    do_read(8'h08);
    drain();
  endtask

  task automatic test_w_before_aw();
    clear_counts();
    @(posedge clk); #1;
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    checks++;
    if (wready !== 1'b1) $display("FAIL wfirst_wready: got %b, required 1", wready);
    else passes++;
    @(posedge clk); #1; wvalid = 0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({wready, bvalid} !== 2'b00) $display("FAIL wfirst_hold: got wready/bvalid=%b, required 00", {wready, bvalid});
      else passes++;
      @(posedge clk); #1;
    end
    exp_b.push_back(model_write(8'h1C, 32'h77, 4'hF));
    awaddr = 8'h1C; awvalid = 1;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1) $display("FAIL wfirst_awready: got %b, required 1", awready);
    else passes++;
    @(posedge clk); #1; awvalid = 0;
    @(negedge clk);
    checks++;
    if ({bvalid, wr_pulse[7], awready, wready} !== 4'b1100)
      $display("FAIL wfirst_resp: got bvalid/pulse/awready/wready=%b, required 1100", {bvalid, wr_pulse[7], awready, wready});
    else passes++;
    drain();
    checks++;
    if (wr_cnt[7] !== 1) $display("FAIL wfirst_single: got %0d pulses, required 1", wr_cnt[7]);
    else passes++;
    do_read(8'h1C);
    drain();
  endtask

  task automatic test_ro_invalid();
    clear_counts();
    do_write(8'h14, 32'h0, 4'hF);
    do_write(8'h40, 32'h12345678, 4'hF);
    do_read(8'h14);
    do_read(8'h40);
    drain();
    checks++;
    if (wr_cnt[5] !== 0 || wr_cnt[0] !== 0 || rd_cnt[5] !== 1)
      $display("FAIL ro_pulses: got wr5=%0d wr0=%0d rd5=%0d, required 0/0/1", wr_cnt[5], wr_cnt[0], rd_cnt[5]);
    else passes++;
  endtask

  task automatic test_stall();
    bready = 0; rready = 0;
    do_write(8'h40, 32'hFFFFFFFF, 4'hF);
    do_read(8'h04);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bvalid, bresp, rvalid, rresp, rdata, arready, awready} !== {1'b1, 2'b10, 1'b1, 2'b00, 32'h2, 1'b0, 1'b0})
        $display("FAIL stall cycle %0d: got bv=%b br=%b rv=%b rr=%b rd=%h ar=%b aw=%b, required 1 10 1 00 00000002 0 0",
                 i, bvalid, bresp, rvalid, rresp, rdata, arready, awready);
      else passes++;
    end
    bready = 1; rready = 1;
    drain();
  endtask

  task automatic test_same_edge();
    @(posedge clk); #1;
    exp_r.push_back(model_read(8'h0C));
    exp_b.push_back(model_write(8'h0C, 32'hCAFE0003, 4'hF));
    awaddr = 8'h0C; araddr = 8'h0C; wdata = 32'hCAFE0003; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) $display("FAIL same_edge_ready: got %b, required 111", {awready, wready, arready});
    else passes++;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    drain();
    do_read(8'h0C);
    drain();
  endtask

  task automatic test_back_to_back();
    int n;
    logic hs;
    n = 0;
    @(posedge clk); #1;
    exp_r.push_back(model_read(8'h00));
    araddr = 8'h00; arvalid = 1;
    for (int c = 0; c < 8 && n < 4; c++) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
      if (hs) begin
        n++;
        if (n < 4) begin
          araddr = 8'(n * 4);
          exp_r.push_back(model_read(8'(n * 4)));
        end else arvalid = 0;
      end
    end
    arvalid = 0;
    checks++;
    if (n !== 4) $display("FAIL b2b_rate: got %0d reads in 8 cycles, required 4", n);
    else passes++;
    drain();
  endtask

  task automatic test_reset_mid();
    bready = 0; rready = 0;
    do_write(8'h00, 32'h0000FFFF, 4'hF);
    do_read(8'h08);
    @(negedge clk);
    checks++;
    if ({bvalid, rvalid} !== 2'b11) $display("FAIL mid_pending: got %b, required 11", {bvalid, rvalid});
    else passes++;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wr_pulse, rd_pulse, reg_out} !== '0)
      $display("FAIL mid_reset_outputs: got nonzero outputs, required 0");
    else passes++;
    exp_b.delete(); exp_r.delete();
    for (int k = 0; k < NR; k++) model[k] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1; bready = 1; rready = 1;
    for (int i = 0; i < 4; i++) do_read(8'(i * 4));
    drain();
  endtask

  initial begin
    hw_status = {NR{32'h5A5A0000}};
    hw_status[5*DW +: DW] = 32'hDEADBEEF;
    for (int k = 0; k < NR; k++) model[k] = '0;
    clear_counts();
    test_reset();
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_ro_invalid();
    test_stall();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
